// File: rtl/code_scan_pkg.sv
// rtl/code_scan_pkg.sv - shared types and constants for the code scan sequencer
package code_scan_pkg;

  localparam int CODE_W            = 4;
  localparam int TIMER_W           = 8;
  localparam int DEFAULT_NUM_CODES = 9;
  localparam int DEFAULT_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - 8-bit clear/enable counter flagging the last allowed wait cycle
module wait_timer
  import code_scan_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Decoded from the register only, so tc never depends on a live input.
  assign tc = (count == LAST);

endmodule

// File: rtl/code_scan_sequencer.sv
// rtl/code_scan_sequencer.sv - walks register codes through the mux and handshakes each one
module code_scan_sequencer
  import code_scan_pkg::*;
#(
  parameter int NUM_CODES = DEFAULT_NUM_CODES,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  output logic [CODE_W-1:0] code1,
  output logic              select,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

  scan_state_t state;
  logic        timer_tc;

  wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state == ISSUE),
    .en   (state == WAIT),
    .tc   (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      code1  <= '0;
      select <= 1'b0;
      req    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          code1 <= '0;
          done  <= 1'b0;
          if (start) begin
            state  <= ISSUE;
            err    <= 1'b0;
            select <= 1'b1;
            req    <= 1'b1;
            busy   <= 1'b1;
          end else begin
            select <= 1'b0;
            req    <= 1'b0;
            busy   <= 1'b0;
          end
        end

        ISSUE: begin
          state  <= WAIT;
          req    <= 1'b0;
          select <= 1'b1;
          busy   <= 1'b1;
        end

        WAIT: begin
          // ack takes priority over a timeout landing on the same cycle.
          if (ack) begin
            if (code1 == LAST_CODE) begin
              state  <= FINISH;
              select <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= ISSUE;
              code1 <= code1 + 1'b1;
              req   <= 1'b1;
            end
          end else if (timer_tc) begin
            state  <= FINISH;
            select <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          code1 <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          code1  <= '0;
          select <= 1'b0;
          req    <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_scan_sequencer.sv
// tb/tb_code_scan_sequencer.sv - directed self-checking bench for code_scan_sequencer
module tb_code_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, ack, start_b, ack_b;
  logic [3:0] code1_a, code1_b;
  logic       select_a, req_a, busy_a, done_a, err_a;
  logic       select_b, req_b, busy_b, done_b, err_b;
  logic [8:0] obs_a, obs_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  code_scan_sequencer #(.NUM_CODES(9), .TIMEOUT(5)) dut_a (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .code1(code1_a), .select(select_a), .req(req_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  code_scan_sequencer #(.NUM_CODES(1), .TIMEOUT(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ack(ack_b),
    .code1(code1_b), .select(select_b), .req(req_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  assign obs_a = {code1_a, select_a, req_a, busy_a, done_a, err_a};
  assign obs_b = {code1_b, select_b, req_b, busy_b, done_b, err_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] pk(input int c, input logic s, input logic r,
                                    input logic b, input logic d, input logic e);
    logic [3:0] cc;
    cc = c[3:0];
    return {cc, s, r, b, d, e};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One code on dut_a: ISSUE, then k WAIT cycles with ack in the k-th.
  task automatic do_code(input int c, input int k, input logic ack_in_issue);
    chk("issue", obs_a, pk(c, 1, 1, 1, 0, 0));
    ack = ack_in_issue;
    tick();
    ack = 1'b0;
    for (int w = 1; w <= k; w++) begin
      chk("wait", obs_a, pk(c, 1, 0, 1, 0, 0));
      if (w == k) ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    tick();
    tick();
    chk("reset_state", obs_a, pk(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();
    chk("idle", obs_a, pk(0, 0, 0, 0, 0, 0));

    // Normal scan: done in cycle 19, start while busy on code 4 ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) start = 1'b1;
      do_code(c, 1, 1'b0);
      start = 1'b0;
    end
    chk("normal_done", obs_a, pk(8, 0, 0, 1, 1, 0));
    tick();
    chk("normal_idle", obs_a, pk(0, 0, 0, 0, 0, 0));

    // Variable latency on code 2 with a stray ack during its ISSUE.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_code(0, 1, 1'b0);
    do_code(1, 1, 1'b0);
    do_code(2, 3, 1'b1);
    for (int c = 3; c < 9; c++) do_code(c, 1, 1'b0);
    chk("latency_done", obs_a, pk(8, 0, 0, 1, 1, 0));
    tick();
    chk("latency_idle", obs_a, pk(0, 0, 0, 0, 0, 0));

    // Timeout on code 3: five WAIT cycles, then done with sticky err.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) do_code(c, 1, 1'b0);
    chk("to_issue", obs_a, pk(3, 1, 1, 1, 0, 0));
    tick();
    for (int w = 1; w <= 5; w++) begin
      chk("to_wait", obs_a, pk(3, 1, 0, 1, 0, 0));
      tick();
    end
    chk("to_finish", obs_a, pk(3, 0, 0, 1, 1, 1));
    tick();
    chk("to_idle_err", obs_a, pk(0, 0, 0, 0, 0, 1));
    tick();
    chk("to_err_sticky", obs_a, pk(0, 0, 0, 0, 0, 1));

    // New start clears err; ack on the terminal timeout cycle advances.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_code(0, 5, 1'b0);
    chk("ack_wins", obs_a, pk(1, 1, 1, 1, 0, 0));
    for (int c = 1; c < 4; c++) do_code(c, 1, 1'b0);
    chk("pre_reset", obs_a, pk(4, 1, 1, 1, 0, 0));

    // Reset mid-scan for three cycles: outputs cleared, no done afterwards.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_reset", obs_a, pk(0, 0, 0, 0, 0, 0));
    end
    reset = 1'b0;
    tick();
    chk("post_reset", obs_a, pk(0, 0, 0, 0, 0, 0));

    // Single-code instance: done in cycle 3.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("one_issue", obs_b, pk(0, 1, 1, 1, 0, 0));
    ack_b = 1'b1;
    tick();
    chk("one_wait", obs_b, pk(0, 1, 0, 1, 0, 0));
    tick();
    ack_b = 1'b0;
    chk("one_done", obs_b, pk(0, 0, 0, 1, 1, 0));
    tick();
    chk("one_idle", obs_b, pk(0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
